// File: rtl/fifo_uart_tx.sv
// Purpose: pops words from a sync FIFO and sends each as a serial frame (start, WIDTH data bits LSB-first, stop).
// Latency: start bit begins 2 cycles after the fifo_rd pulse; one word takes (WIDTH+2)*CLKS_PER_BIT+2 cycles.
// Backpressure: fifo_empty is evaluated only at a frame boundary, and a read is issued only when the FIFO is non-empty.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd,
  output logic             tx,
  output logic             busy,
  output logic [15:0]      frames_sent
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(WIDTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              rd_q, rd_d;
  logic              busy_q, busy_d;
  logic [15:0]       frames_q, frames_d;
  logic              baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  // Next-state and next-output logic; a cycle in IDLE with rd_q set is the FIFO read cycle.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    rd_d     = 1'b0;
    busy_d   = busy_q;
    frames_d = frames_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (rd_q) begin
          // Read already issued; data shows up on fifo_data during LOAD.
          state_d = LOAD;
        end else if (!fifo_empty) begin
          rd_d   = 1'b1;
          busy_d = 1'b1;
        end
      end
      LOAD: begin
        shift_d = fifo_data;
        baud_d  = '0;
        tx_d    = 1'b0;
        state_d = START;
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            tx_d  = shift_d[0];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d   = '0;
          idx_d    = '0;
          frames_d = frames_q + 16'd1;
          state_d  = IDLE;
          // Issue the next read on the boundary itself so back-to-back words
          // cost only the read cycle plus LOAD between stop and start.
          if (!fifo_empty) begin
            rd_d   = 1'b1;
            busy_d = 1'b1;
          end else begin
            busy_d = 1'b0;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards any in-flight word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      frames_q <= frames_d;
    end
  end

  assign fifo_rd     = rd_q;
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign frames_sent = frames_q;

endmodule
